// File: rtl/dispatch_ctrl.sv
// Instruction queue and dispatch sequencer: buffers fetched words in a circular
// FIFO, presents the head to the decoder and routes it to RS or LSB plus ROB.
//
// state    | meaning
// ---------|--------------------------------------------------------------
// ST_RUN   | normal operation: accept pushes, dispatch head when targets allow
// ST_FLUSH | one cycle after a clear; blocks the fetcher's stale in-flight word
module dispatch_ctrl #(
   parameter int         IQ_DEPTH = 16,
   parameter int         IQ_AW    = $clog2(IQ_DEPTH),
   parameter logic [2:0] TYPE_LD  = 3'd1,
   parameter logic [2:0] TYPE_ST  = 3'd2
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        rdy_in,
   input  logic        clear_in,
   input  logic        if_valid,
   input  logic [31:0] if_inst,
   input  logic [31:0] if_pc,
   output logic        if_ready,
   output logic        dec_inst_flag,
   output logic [31:0] dec_inst,
   input  logic [2:0]  dec_inst_type,
   input  logic [5:0]  dec_inst_code,
   input  logic [4:0]  dec_rd,
   input  logic [4:0]  dec_rs1,
   input  logic [4:0]  dec_rs2,
   input  logic [31:0] dec_imm,
   input  logic        rob_full,
   input  logic        rs_full,
   input  logic        lsb_full,
   output logic        disp_rob_en,
   output logic        disp_rs_en,
   output logic        disp_lsb_en,
   output logic [31:0] disp_pc,
   output logic [5:0]  disp_inst_code,
   output logic [2:0]  disp_inst_type,
   output logic [4:0]  disp_rd,
   output logic [4:0]  disp_rs1,
   output logic [4:0]  disp_rs2,
   output logic [31:0] disp_imm
);

   typedef enum logic {ST_RUN, ST_FLUSH} state_t;

   localparam logic [IQ_AW:0]   CNT_FULL = (IQ_AW+1)'(IQ_DEPTH);
   localparam logic [IQ_AW:0]   CNT_ONE  = {{IQ_AW{1'b0}}, 1'b1};
   localparam logic [IQ_AW-1:0] PTR_ONE  = {{(IQ_AW-1){1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic [IQ_AW-1:0]  head_q, tail_q;
   logic [IQ_AW:0]    count_q;
   logic [31:0]       mem_inst [IQ_DEPTH];
   logic [31:0]       mem_pc   [IQ_DEPTH];

   logic is_mem, tgt_full, push, pop;

   always_comb begin
      state_d       = state_q;
      if_ready      = 1'b0;
      dec_inst_flag = 1'b0;
      case (state_q)
         ST_RUN: begin
            if_ready      = (count_q != CNT_FULL) && !clear_in;
            dec_inst_flag = (count_q != '0);
            if (clear_in) state_d = ST_FLUSH;
         end
         ST_FLUSH: state_d = ST_RUN;
         default:  state_d = ST_RUN;
      endcase
   end

   // Loads and stores go to the LSB; every other class goes to the RS.
   assign is_mem   = (dec_inst_type == TYPE_LD) || (dec_inst_type == TYPE_ST);
   assign tgt_full = is_mem ? lsb_full : rs_full;
   assign push     = if_valid && if_ready && rdy_in;
   assign pop      = dec_inst_flag && rdy_in && !clear_in && !rob_full && !tgt_full;
   assign dec_inst = mem_inst[head_q];

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= ST_RUN;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (rdy_in) begin
         state_q <= state_d;
         if (clear_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
         end else begin
            if (push) tail_q <= tail_q + PTR_ONE;
            if (pop)  head_q <= head_q + PTR_ONE;
            case ({push, pop})
               2'b10:   count_q <= count_q + CNT_ONE;
               2'b01:   count_q <= count_q - CNT_ONE;
               default: count_q <= count_q;
            endcase
         end
      end
   end

   // Storage needs no reset: occupancy is tracked solely by count_q.
   always_ff @(posedge clk_in) begin
      if (push) begin
         mem_inst[tail_q] <= if_inst;
         mem_pc[tail_q]   <= if_pc;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         disp_rob_en    <= 1'b0;
         disp_rs_en     <= 1'b0;
         disp_lsb_en    <= 1'b0;
         disp_pc        <= '0;
         disp_inst_code <= '0;
         disp_inst_type <= '0;
         disp_rd        <= '0;
         disp_rs1       <= '0;
         disp_rs2       <= '0;
         disp_imm       <= '0;
      end else begin
         disp_rob_en <= pop;
         disp_rs_en  <= pop && !is_mem;
         disp_lsb_en <= pop && is_mem;
         if (pop) begin
            disp_pc        <= mem_pc[head_q];
            disp_inst_code <= dec_inst_code;
            disp_inst_type <= dec_inst_type;
            disp_rd        <= dec_rd;
            disp_rs1       <= dec_rs1;
            disp_rs2       <= dec_rs2;
            disp_imm       <= dec_imm;
         end
      end
   end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl with a small RISC-V style decoder stub.
module tb_dispatch_ctrl;

   localparam logic [2:0] T_ALU = 3'd0, T_LD = 3'd1, T_ST = 3'd2, T_BRC = 3'd3, T_JMP = 3'd4;
   localparam logic [31:0] I_ADDI = 32'h0050_0093;  // addi x1,x0,5
   localparam logic [31:0] I_LW   = 32'h0000_A103;  // lw x2,0(x1)
   localparam logic [31:0] I_BEQ  = 32'h0020_8463;  // beq x1,x2,8
   localparam logic [31:0] I_ADD  = 32'h0020_81B3;  // add x3,x1,x2

   logic        clk_in = 1'b0, rst_n_in = 1'b0, rdy_in = 1'b1, clear_in = 1'b0;
   logic        if_valid = 1'b0, if_ready;
   logic [31:0] if_inst = '0, if_pc = '0;
   logic        dec_inst_flag;
   logic [31:0] dec_inst;
   logic [2:0]  dec_inst_type;
   logic [5:0]  dec_inst_code;
   logic [4:0]  dec_rd, dec_rs1, dec_rs2;
   logic [31:0] dec_imm;
   logic        rob_full = 1'b0, rs_full = 1'b0, lsb_full = 1'b0;
   logic        disp_rob_en, disp_rs_en, disp_lsb_en;
   logic [31:0] disp_pc, disp_imm;
   logic [5:0]  disp_inst_code;
   logic [2:0]  disp_inst_type;
   logic [4:0]  disp_rd, disp_rs1, disp_rs2;

   int errors = 0;
   int checks = 0;

   dispatch_ctrl dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear_in(clear_in),
      .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_ready(if_ready),
      .dec_inst_flag(dec_inst_flag), .dec_inst(dec_inst),
      .dec_inst_type(dec_inst_type), .dec_inst_code(dec_inst_code),
      .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_imm(dec_imm),
      .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
      .disp_rob_en(disp_rob_en), .disp_rs_en(disp_rs_en), .disp_lsb_en(disp_lsb_en),
      .disp_pc(disp_pc), .disp_inst_code(disp_inst_code), .disp_inst_type(disp_inst_type),
      .disp_rd(disp_rd), .disp_rs1(disp_rs1), .disp_rs2(disp_rs2), .disp_imm(disp_imm)
   );

   always #5 clk_in = ~clk_in;

   // Decoder stub: class from opcode, code = {funct3, opcode[4:2]}, I-type immediate.
   always_comb begin
      dec_inst_type = T_ALU;
      case (dec_inst[6:0])
         7'b0000011: dec_inst_type = T_LD;
         7'b0100011: dec_inst_type = T_ST;
         7'b1100011: dec_inst_type = T_BRC;
         7'b1101111: dec_inst_type = T_JMP;
         default:    dec_inst_type = T_ALU;
      endcase
      dec_inst_code = {dec_inst[14:12], dec_inst[4:2]};
      dec_rd        = dec_inst[11:7];
      dec_rs1       = dec_inst[19:15];
      dec_rs2       = dec_inst[24:20];
      dec_imm       = {{20{dec_inst[31]}}, dec_inst[31:20]};
   end

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({disp_rob_en, disp_rs_en, disp_lsb_en} !== 3'b000 || disp_pc !== 32'h0 || disp_imm !== 32'h0) begin
         errors++;
         $display("FAIL reset_disp: en=%b pc=%h imm=%h, required en=000 pc=0 imm=0",
                  {disp_rob_en, disp_rs_en, disp_lsb_en}, disp_pc, disp_imm);
      end
      checks++;
      if ({disp_inst_code, disp_inst_type, disp_rd, disp_rs1, disp_rs2} !== 24'h0 || dec_inst_flag !== 1'b0) begin
         errors++;
         $display("FAIL reset_fields: fields=%h flag=%b, required 0 and 0",
                  {disp_inst_code, disp_inst_type, disp_rd, disp_rs1, disp_rs2}, dec_inst_flag);
      end
      @(negedge clk_in);
      rst_n_in = 1'b1;
      #1;
      checks++;
      if (if_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_if_ready: got %b, required 1", if_ready);
      end
   endtask

   task automatic test_basic_dispatch();
      if_valid = 1'b1; if_inst = I_ADDI; if_pc = 32'h0;
      step();
      checks++;
      if (dec_inst_flag !== 1'b1 || disp_rob_en !== 1'b0) begin
         errors++;
         $display("FAIL basic_latency1: flag=%b rob_en=%b, required 1 0", dec_inst_flag, disp_rob_en);
      end
      if_inst = I_LW; if_pc = 32'h4;
      step();
      checks++;
      if ({disp_rob_en, disp_rs_en, disp_lsb_en} !== 3'b110 || disp_pc !== 32'h0 ||
          disp_rd !== 5'd1 || disp_imm !== 32'd5 || disp_inst_type !== T_ALU || disp_inst_code !== 6'd4) begin
         errors++;
         $display("FAIL basic_addi: en=%b pc=%h rd=%0d imm=%h type=%0d code=%0d, required 110 0 1 5 0 4",
                  {disp_rob_en, disp_rs_en, disp_lsb_en}, disp_pc, disp_rd, disp_imm, disp_inst_type, disp_inst_code);
      end
      if_inst = I_BEQ; if_pc = 32'h8;
      step();
      checks++;
      if ({disp_rob_en, disp_rs_en, disp_lsb_en} !== 3'b101 || disp_pc !== 32'h4 || disp_rd !== 5'd2 ||
          disp_rs1 !== 5'd1 || disp_inst_type !== T_LD || disp_inst_code !== 6'd16 || disp_imm !== 32'h0) begin
         errors++;
         $display("FAIL basic_lw: en=%b pc=%h rd=%0d rs1=%0d type=%0d code=%0d, required 101 4 2 1 1 16",
                  {disp_rob_en, disp_rs_en, disp_lsb_en}, disp_pc, disp_rd, disp_rs1, disp_inst_type, disp_inst_code);
      end
      if_valid = 1'b0;
      step();
      checks++;
      if ({disp_rob_en, disp_rs_en, disp_lsb_en} !== 3'b110 || disp_pc !== 32'h8 || disp_inst_type !== T_BRC) begin
         errors++;
         $display("FAIL basic_beq: en=%b pc=%h type=%0d, required 110 8 3",
                  {disp_rob_en, disp_rs_en, disp_lsb_en}, disp_pc, disp_inst_type);
      end
      step();
      checks++;
      if (disp_rob_en !== 1'b0 || dec_inst_flag !== 1'b0) begin
         errors++;
         $display("FAIL basic_idle: rob_en=%b flag=%b, required 0 0", disp_rob_en, dec_inst_flag);
      end
   endtask

   task automatic test_full_backpressure();
      lsb_full = 1'b1; if_valid = 1'b1; if_inst = I_LW;
      for (int i = 0; i < 16; i++) begin
         if_pc = 32'h1000 + 32'(4 * i);
         step();
      end
      checks++;
      if (if_ready !== 1'b0 || dec_inst_flag !== 1'b1 || disp_rob_en !== 1'b0) begin
         errors++;
         $display("FAIL full_at16: if_ready=%b flag=%b rob_en=%b, required 0 1 0", if_ready, dec_inst_flag, disp_rob_en);
      end
      if_pc = 32'hDEAD_0000;
      step();
      if_valid = 1'b0;
      checks++;
      if (if_ready !== 1'b0 || disp_rob_en !== 1'b0) begin
         errors++;
         $display("FAIL full_hold: if_ready=%b rob_en=%b, required 0 0", if_ready, disp_rob_en);
      end
      lsb_full = 1'b0;
      step();
      checks++;
      if (if_ready !== 1'b1 || disp_lsb_en !== 1'b1 || disp_pc !== 32'h1000) begin
         errors++;
         $display("FAIL full_release: if_ready=%b lsb_en=%b pc=%h, required 1 1 1000", if_ready, disp_lsb_en, disp_pc);
      end
      for (int i = 1; i < 16; i++) begin
         step();
         checks++;
         if (disp_lsb_en !== 1'b1 || disp_rs_en !== 1'b0 || disp_pc !== 32'h1000 + 32'(4 * i)) begin
            errors++;
            $display("FAIL full_drain: lsb_en=%b rs_en=%b pc=%h, required 1 0 %h",
                     disp_lsb_en, disp_rs_en, disp_pc, 32'h1000 + 32'(4 * i));
         end
      end
      step();
      checks++;
      if (disp_rob_en !== 1'b0 || dec_inst_flag !== 1'b0) begin
         errors++;
         $display("FAIL full_empty: rob_en=%b flag=%b, required 0 0", disp_rob_en, dec_inst_flag);
      end
   endtask

   task automatic test_rob_stall();
      rob_full = 1'b1; if_valid = 1'b1; if_inst = I_ADD; if_pc = 32'h200;
      step();
      if_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         checks++;
         if ({disp_rob_en, disp_rs_en, disp_lsb_en} !== 3'b000) begin
            errors++;
            $display("FAIL rob_stall: cycle %0d en=%b, required 000", k, {disp_rob_en, disp_rs_en, disp_lsb_en});
         end
      end
      rob_full = 1'b0;
      step();
      checks++;
      if ({disp_rob_en, disp_rs_en, disp_lsb_en} !== 3'b110 || disp_pc !== 32'h200) begin
         errors++;
         $display("FAIL rob_release: en=%b pc=%h, required 110 200", {disp_rob_en, disp_rs_en, disp_lsb_en}, disp_pc);
      end
      step();
      checks++;
      if (disp_rob_en !== 1'b0) begin
         errors++;
         $display("FAIL rob_single_pulse: rob_en=%b, required 0", disp_rob_en);
      end
   endtask

   task automatic test_clear();
      rs_full = 1'b1; if_valid = 1'b1; if_inst = I_ADD;
      for (int i = 0; i < 8; i++) begin
         if_pc = 32'h500 + 32'(4 * i);
         step();
      end
      clear_in = 1'b1; if_inst = I_ADDI; if_pc = 32'h100;
      #1;
      checks++;
      if (if_ready !== 1'b0) begin
         errors++;
         $display("FAIL clear_cycle_ready: got %b, required 0", if_ready);
      end
      step();
      clear_in = 1'b0; rs_full = 1'b0;
      #1;
      checks++;
      if (disp_rob_en !== 1'b0 || dec_inst_flag !== 1'b0 || if_ready !== 1'b0) begin
         errors++;
         $display("FAIL clear_flush: rob_en=%b flag=%b if_ready=%b, required 0 0 0", disp_rob_en, dec_inst_flag, if_ready);
      end
      step();
      checks++;
      if (if_ready !== 1'b1 || dec_inst_flag !== 1'b0 || disp_rob_en !== 1'b0) begin
         errors++;
         $display("FAIL clear_run: if_ready=%b flag=%b rob_en=%b, required 1 0 0", if_ready, dec_inst_flag, disp_rob_en);
      end
      step();
      if_valid = 1'b0;
      checks++;
      if (dec_inst_flag !== 1'b1 || disp_rob_en !== 1'b0) begin
         errors++;
         $display("FAIL clear_push: flag=%b rob_en=%b, required 1 0", dec_inst_flag, disp_rob_en);
      end
      step();
      checks++;
      if (disp_rs_en !== 1'b1 || disp_pc !== 32'h100) begin
         errors++;
         $display("FAIL clear_new_dispatch: rs_en=%b pc=%h, required 1 100", disp_rs_en, disp_pc);
      end
      step();
      checks++;
      if (disp_rob_en !== 1'b0 || dec_inst_flag !== 1'b0) begin
         errors++;
         $display("FAIL clear_no_stale: rob_en=%b flag=%b, required 0 0", disp_rob_en, dec_inst_flag);
      end
   endtask

   task automatic test_back_to_back_wrap();
      int pushed = 0, popped = 0, cycle = 0;
      logic [31:0] exp_pc = 32'h3000;
      logic accepted;
      if_inst = I_ADD;
      while (popped < 40 && cycle < 300) begin
         if_valid = (pushed < 40);
         if_pc    = 32'h3000 + 32'(4 * pushed);
         rs_full  = (cycle >= 6 && cycle < 26);
         #1;
         accepted = if_valid && if_ready;
         step();
         if (accepted) pushed++;
         if (disp_rob_en === 1'b1) begin
            checks++;
            if (disp_pc !== exp_pc || disp_rs_en !== 1'b1) begin
               errors++;
               $display("FAIL wrap_order: pc=%h rs_en=%b, required %h 1", disp_pc, disp_rs_en, exp_pc);
            end
            exp_pc = exp_pc + 32'h4;
            popped++;
         end
         cycle++;
      end
      if_valid = 1'b0; rs_full = 1'b0;
      checks++;
      if (popped != 40 || pushed != 40) begin
         errors++;
         $display("FAIL wrap_count: dispatched=%0d pushed=%0d, required 40 40", popped, pushed);
      end
      step();
      checks++;
      if (disp_rob_en !== 1'b0 || dec_inst_flag !== 1'b0) begin
         errors++;
         $display("FAIL wrap_no_dup: rob_en=%b flag=%b, required 0 0", disp_rob_en, dec_inst_flag);
      end
   endtask

   task automatic test_freeze_and_reset();
      rs_full = 1'b1; if_valid = 1'b1; if_inst = I_ADD;
      for (int i = 0; i < 4; i++) begin
         if_pc = 32'h400 + 32'(4 * i);
         step();
      end
      if_pc = 32'h999; rs_full = 1'b0; rdy_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (disp_rob_en !== 1'b0 || disp_pc !== 32'h309C || dec_inst_flag !== 1'b1) begin
            errors++;
            $display("FAIL freeze: cycle %0d rob_en=%b pc=%h flag=%b, required 0 309c 1", k, disp_rob_en, disp_pc, dec_inst_flag);
         end
      end
      rdy_in = 1'b1; if_valid = 1'b0;
      step();
      checks++;
      if (disp_rs_en !== 1'b1 || disp_pc !== 32'h400) begin
         errors++;
         $display("FAIL unfreeze_first: rs_en=%b pc=%h, required 1 400", disp_rs_en, disp_pc);
      end
      step();
      checks++;
      if (disp_rs_en !== 1'b1 || disp_pc !== 32'h404) begin
         errors++;
         $display("FAIL unfreeze_second: rs_en=%b pc=%h, required 1 404", disp_rs_en, disp_pc);
      end
      #2;
      rst_n_in = 1'b0;
      #1;
      checks++;
      if ({disp_rob_en, disp_rs_en, disp_lsb_en} !== 3'b000 || disp_pc !== 32'h0 || disp_imm !== 32'h0 ||
          disp_inst_type !== 3'd0 || dec_inst_flag !== 1'b0) begin
         errors++;
         $display("FAIL midreset_outputs: en=%b pc=%h imm=%h type=%0d flag=%b, required 000 0 0 0 0",
                  {disp_rob_en, disp_rs_en, disp_lsb_en}, disp_pc, disp_imm, disp_inst_type, dec_inst_flag);
      end
      @(negedge clk_in);
      rst_n_in = 1'b1;
      step();
      checks++;
      if (dec_inst_flag !== 1'b0 || disp_rob_en !== 1'b0 || if_ready !== 1'b1) begin
         errors++;
         $display("FAIL midreset_empty: flag=%b rob_en=%b if_ready=%b, required 0 0 1", dec_inst_flag, disp_rob_en, if_ready);
      end
   endtask

   initial begin
      test_reset();
      test_basic_dispatch();
      test_full_backpressure();
      test_rob_stall();
      test_clear();
      test_back_to_back_wrap();
      test_freeze_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "timeout");
   end

endmodule
